stall_ctrl_gen: RTL and testbench

Parametrised pipeline stall controller between instruction decode and program-memory fetch. It decodes the fetched opcode against programmable jump, load and halt patterns, and holds `stall` for a configurable number of cycles per hazard class. It latches halt until an explicit resume pulse, and drives a registered `stall_pm` copy of the stall for the program-memory address path. A saturating counter accumulates total stall cycles for performance monitoring.

---
 rtl/stall_ctrl_gen_if.sv | 31 +++
 rtl/stall_ctrl_gen.sv | 116 +++++++++++
 tb/tb_stall_ctrl_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stall_ctrl_gen_if.sv
// Decode-side bundle between the pipeline and the stall controller.
// master = pipeline (drives opcode/resume), slave = stall controller.
interface stall_ctrl_gen_if #(
    parameter int unsigned OP_W  = 6,
    parameter int unsigned CNT_W = 16
);
    logic [OP_W-1:0]  op;
    logic             resume;
    logic             stall;
    logic             stall_pm;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output op,
        output resume,
        input  stall,
        input  stall_pm,
        input  halted,
        input  stall_cnt
    );

    modport slave (
        input  op,
        input  resume,
        output stall,
        output stall_pm,
        output halted,
        output stall_cnt
    );
endinterface

// File: rtl/stall_ctrl_gen.sv
// Pipeline stall controller: decodes jump/load/halt opcodes, holds stall for a
// per-class cycle count, latches halt until resume, and counts stall cycles.
module stall_ctrl_gen #(
    parameter int unsigned     OP_W     = 6,
    parameter logic [OP_W-1:0] JMP_MASK = 6'b111100,
    parameter logic [OP_W-1:0] JMP_VAL  = 6'b011100,
    parameter logic [OP_W-1:0] LD_MASK  = 6'b111111,
    parameter logic [OP_W-1:0] LD_VAL   = 6'b010100,
    parameter logic [OP_W-1:0] HLT_VAL  = 6'b010001,
    parameter int unsigned     JMP_CYC  = 2,
    parameter int unsigned     LD_CYC   = 1,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    stall_ctrl_gen_if.slave bus
);
    localparam int unsigned MAX_CYC = (JMP_CYC > LD_CYC) ? JMP_CYC : LD_CYC;
    localparam int unsigned REM_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [REM_W-1:0] JMP_REM = REM_W'((JMP_CYC > 1) ? JMP_CYC - 2 : 0);
    localparam logic [REM_W-1:0] LD_REM  = REM_W'((LD_CYC > 1) ? LD_CYC - 2 : 0);

    typedef enum logic [1:0] {IDLE, JSTALL, LSTALL, HALT} state_t;

    state_t           state_q;
    logic             armed_q;
    logic [REM_W-1:0] rem_q;
    logic             stall_pm_q;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic hit_hlt;
    logic hit_jmp;
    logic hit_ld;
    logic stall_raw;
    logic stall_c;

    always_comb begin
        hit_hlt = (bus.op == HLT_VAL);
        hit_jmp = ((bus.op & JMP_MASK) == JMP_VAL);
        hit_ld  = ((bus.op & LD_MASK) == LD_VAL);
        if (state_q == IDLE) begin
            stall_raw = armed_q & (hit_hlt | hit_jmp | hit_ld);
        end else begin
            stall_raw = 1'b1;
        end
        // Gating with the async reset drops stall the moment reset asserts.
        stall_c = stall_raw & reset;
        cnt_d   = (stall_c && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            armed_q    <= 1'b1;
            rem_q      <= '0;
            stall_pm_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            stall_pm_q <= stall_c;
            cnt_q      <= cnt_d;
            case (state_q)
                IDLE: begin
                    // A disarmed IDLE cycle lets the stalled instruction issue.
                    if (!armed_q) begin
                        armed_q <= 1'b1;
                    end else if (hit_hlt) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (hit_jmp) begin
                        if (JMP_CYC == 1) begin
                            armed_q <= 1'b0;
                        end else begin
                            state_q <= JSTALL;
                            rem_q   <= JMP_REM;
                        end
                    end else if (hit_ld) begin
                        if (LD_CYC == 1) begin
                            armed_q <= 1'b0;
                        end else begin
                            state_q <= LSTALL;
                            rem_q   <= LD_REM;
                        end
                    end
                end
                JSTALL, LSTALL: begin
                    if (rem_q == '0) begin
                        state_q <= IDLE;
                        armed_q <= 1'b0;
                    end else begin
                        rem_q <= rem_q - 1'b1;
                    end
                end
                HALT: begin
                    if (bus.resume) begin
                        state_q  <= IDLE;
                        armed_q  <= 1'b0;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    armed_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.stall     = stall_c;
    assign bus.stall_pm  = stall_pm_q;
    assign bus.halted    = halted_q;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_stall_ctrl_gen.sv
// Bench for stall_ctrl_gen: three configurations driven in lockstep, checked
// every cycle against a cycle-schedule model plus hand-computed expectations.
module tb_stall_ctrl_gen;
    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_JMP = 6'b011100;
    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_HLT = 6'b010001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op_r = '0;
    logic       resume_r = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stall_ctrl_gen_if #(.OP_W(6), .CNT_W(16)) if0 ();
    stall_ctrl_gen_if #(.OP_W(6), .CNT_W(16)) if1 ();
    stall_ctrl_gen_if #(.OP_W(6), .CNT_W(4))  if2 ();

    assign if0.op = op_r;
    assign if1.op = op_r;
    assign if2.op = op_r;
    assign if0.resume = resume_r;
    assign if1.resume = resume_r;
    assign if2.resume = resume_r;

    stall_ctrl_gen u0 (.clk(clk), .reset(reset), .bus(if0));
    stall_ctrl_gen #(.LD_CYC(3)) u1 (.clk(clk), .reset(reset), .bus(if1));
    stall_ctrl_gen #(.CNT_W(4)) u2 (.clk(clk), .reset(reset), .bus(if2));

    // Model: per DUT, the absolute cycle numbers of the pending stall window
    // and of the following disarmed cycle, plus a halt flag.
    int          m_jc[3]   = '{2, 2, 2};
    int          m_lc[3]   = '{1, 3, 1};
    int unsigned m_cmax[3] = '{65535, 65535, 15};
    int          cyc = 0;
    int          m_busy[3];
    int          m_quiet[3];
    bit          m_halt[3];
    bit          m_pm[3];
    int unsigned m_cnt[3];
    bit          m_s;

    function automatic bit model_stall(input int d);
        if (!reset) return 1'b0;
        if (m_halt[d]) return 1'b1;
        if (cyc <= m_busy[d]) return 1'b1;
        if (cyc == m_quiet[d]) return 1'b0;
        return (op_r == OP_HLT) || ((op_r & 6'b111100) == 6'b011100) || (op_r == 6'b010100);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                m_halt[d]  = 1'b0;
                m_busy[d]  = -10;
                m_quiet[d] = -10;
                m_pm[d]    = 1'b0;
                m_cnt[d]   = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                m_s = model_stall(d);
                if (m_halt[d]) begin
                    if (resume_r) begin
                        m_halt[d]  = 1'b0;
                        m_quiet[d] = cyc + 1;
                    end
                end else if (cyc <= m_busy[d] || cyc == m_quiet[d]) begin
                    m_halt[d] = 1'b0;
                end else if (op_r == OP_HLT) begin
                    m_halt[d] = 1'b1;
                end else if ((op_r & 6'b111100) == 6'b011100) begin
                    m_busy[d]  = cyc + m_jc[d] - 1;
                    m_quiet[d] = cyc + m_jc[d];
                end else if (op_r == 6'b010100) begin
                    m_busy[d]  = cyc + m_lc[d] - 1;
                    m_quiet[d] = cyc + m_lc[d];
                end
                if (m_s && m_cnt[d] < m_cmax[d]) m_cnt[d] = m_cnt[d] + 1;
                m_pm[d] = m_s;
            end
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic st, input logic pm, input logic hl,
                           input logic [15:0] cn);
        chk($sformatf("model_d%0d_stall", d), {31'd0, st}, {31'd0, model_stall(d)});
        chk($sformatf("model_d%0d_stall_pm", d), {31'd0, pm}, {31'd0, m_pm[d]});
        chk($sformatf("model_d%0d_halted", d), {31'd0, hl}, {31'd0, m_halt[d]});
        chk($sformatf("model_d%0d_stall_cnt", d), {16'd0, cn}, m_cnt[d]);
    endtask

    always @(negedge clk) begin
        cmp_dut(0, if0.stall, if0.stall_pm, if0.halted, if0.stall_cnt);
        cmp_dut(1, if1.stall, if1.stall_pm, if1.halted, if1.stall_cnt);
        cmp_dut(2, if2.stall, if2.stall_pm, if2.halted, {12'd0, if2.stall_cnt});
    end

    task automatic cyc_in(input logic [5:0] o, input logic r);
        @(posedge clk);
        #1;
        op_r = o;
        resume_r = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        op_r = OP_NOP;
        resume_r = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    int exp_j_s[4]   = '{1, 1, 0, 1};
    int exp_j_pm[4]  = '{0, 1, 1, 0};
    int exp_l1_s[5]  = '{1, 1, 1, 0, 1};
    int exp_l0_s[5]  = '{1, 0, 1, 0, 1};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cyc_in(OP_NOP, 1'b0);
            chk("idle_stall", {31'd0, if0.stall}, 0);
            chk("idle_stall_pm", {31'd0, if0.stall_pm}, 0);
            chk("idle_halted", {31'd0, if0.halted}, 0);
            chk("idle_cnt", {16'd0, if0.stall_cnt}, 0);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc_in(OP_JMP, 1'b0);
            chk($sformatf("jmp_stall_c%0d", i), {31'd0, if0.stall}, exp_j_s[i]);
            chk($sformatf("jmp_stall_pm_c%0d", i), {31'd0, if0.stall_pm}, exp_j_pm[i]);
            if (i == 2) chk("jmp_cnt_c2", {16'd0, if0.stall_cnt}, 2);
        end
        repeat (3) cyc_in(OP_NOP, 1'b0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc_in(OP_LD, 1'b0);
            chk($sformatf("ld3_stall_c%0d", i), {31'd0, if1.stall}, exp_l1_s[i]);
            chk($sformatf("ld1_stall_c%0d", i), {31'd0, if0.stall}, exp_l0_s[i]);
            if (i == 3) chk("ld3_cnt_c3", {16'd0, if1.stall_cnt}, 3);
        end
        repeat (4) cyc_in(OP_NOP, 1'b0);

        do_reset();
        cyc_in(OP_NOP, 1'b1);
        chk("idle_resume_stall", {31'd0, if0.stall}, 0);
        cyc_in(OP_NOP, 1'b0);
        chk("idle_resume_halted", {31'd0, if0.halted}, 0);
        cyc_in(OP_HLT, 1'b0);
        chk("hlt_c0_stall", {31'd0, if0.stall}, 1);
        chk("hlt_c0_halted", {31'd0, if0.halted}, 0);
        for (int c = 1; c <= 10; c++) begin
            cyc_in(OP_JMP, (c == 10));
            chk($sformatf("hlt_c%0d_stall", c), {31'd0, if0.stall}, 1);
            chk($sformatf("hlt_c%0d_halted", c), {31'd0, if0.halted}, 1);
        end
        cyc_in(OP_JMP, 1'b0);
        chk("resume_c11_stall", {31'd0, if0.stall}, 0);
        chk("resume_c11_halted", {31'd0, if0.halted}, 0);
        chk("resume_c11_cnt", {16'd0, if0.stall_cnt}, 11);
        cyc_in(OP_JMP, 1'b0);
        chk("resume_c12_decode", {31'd0, if0.stall}, 1);
        repeat (3) cyc_in(OP_NOP, 1'b0);

        do_reset();
        cyc_in(OP_HLT, 1'b1);
        chk("hlt_resume_same_stall", {31'd0, if0.stall}, 1);
        cyc_in(OP_NOP, 1'b0);
        chk("hlt_resume_same_halted", {31'd0, if0.halted}, 1);
        cyc_in(OP_NOP, 1'b1);
        chk("hlt_resume2_stall", {31'd0, if0.stall}, 1);
        cyc_in(OP_NOP, 1'b0);
        chk("hlt_resume2_halted", {31'd0, if0.halted}, 0);
        chk("hlt_resume2_stall_low", {31'd0, if0.stall}, 0);
        repeat (2) cyc_in(OP_NOP, 1'b0);

        do_reset();
        for (int i = 0; i <= 20; i++) begin
            cyc_in(OP_HLT, 1'b0);
            if (i >= 15) chk($sformatf("sat_cnt_c%0d", i), {28'd0, if2.stall_cnt}, 15);
        end
        chk("sat_wide_cnt_c20", {16'd0, if0.stall_cnt}, 20);
        #2;
        reset = 1'b0;
        op_r = OP_NOP;
        #1;
        chk("async_hlt_halted", {31'd0, if0.halted}, 0);
        chk("async_hlt_stall", {31'd0, if0.stall}, 0);
        chk("async_hlt_cnt", {28'd0, if2.stall_cnt}, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        cyc_in(OP_JMP, 1'b0);
        chk("js_c0_stall", {31'd0, if0.stall}, 1);
        cyc_in(OP_NOP, 1'b0);
        chk("js_c1_stall", {31'd0, if0.stall}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_js_stall", {31'd0, if0.stall}, 0);
        chk("async_js_halted", {31'd0, if0.halted}, 0);
        chk("async_js_stall_pm", {31'd0, if0.stall_pm}, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        cyc_in(OP_JMP, 1'b0);
        chk("post_reset_armed_stall", {31'd0, if0.stall}, 1);
        repeat (3) cyc_in(OP_NOP, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
